// File: rtl/div_sched_rr_if.sv
// Request/result bus of the shared round-robin divider.
// DIV_SCHED_DBZ_FLAG_EN adds the o_dbz divide-by-zero flag to the result side.
interface div_sched_rr_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       i_valid;
  logic [NUM_REQ-1:0]       i_ready;
  logic [NUM_REQ*WIDTH-1:0] i_payload_dividend;
  logic [NUM_REQ*WIDTH-1:0] i_payload_divisor;
  logic                     o_valid;
  logic                     o_ready;
  logic [WIDTH-1:0]         o_payload_1;
  logic [WIDTH-1:0]         o_payload_2;
  logic [ID_W-1:0]          o_id;
`ifdef DIV_SCHED_DBZ_FLAG_EN
  logic                     o_dbz;

  modport slave (
    input  i_valid, i_payload_dividend, i_payload_divisor, o_ready,
    output i_ready, o_valid, o_payload_1, o_payload_2, o_id, o_dbz
  );
  modport master (
    output i_valid, i_payload_dividend, i_payload_divisor, o_ready,
    input  i_ready, o_valid, o_payload_1, o_payload_2, o_id, o_dbz
  );
`else
  modport slave (
    input  i_valid, i_payload_dividend, i_payload_divisor, o_ready,
    output i_ready, o_valid, o_payload_1, o_payload_2, o_id
  );
  modport master (
    output i_valid, i_payload_dividend, i_payload_divisor, o_ready,
    input  i_ready, o_valid, o_payload_1, o_payload_2, o_id
  );
`endif
endinterface

// File: rtl/div_sched_rr.sv
// One restoring unsigned divider (1 quotient bit/cycle) shared round-robin by NUM_REQ requesters.
// Optional DIV_SCHED_DBZ_FLAG_EN drives o_dbz alongside a divide-by-zero result.
module div_sched_rr #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  div_sched_rr_if.slave   bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              dbz_q, dbz_d;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_dvd, sel_dsr;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH-1:0]  rem_sub;
  logic              q_bit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && bus.i_valid[PTR_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dsr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        sel_dvd = bus.i_payload_dividend[k*WIDTH +: WIDTH];
        sel_dsr = bus.i_payload_divisor[k*WIDTH +: WIDTH];
      end
    end
  end

  // The compare needs the bit shifted out of rem, hence WIDTH+1 bits.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, dsr_q});
  assign rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;

  // NOTE: async reset clears every register, datapath included, so outputs read 0 out of reset;
  // non-blocking assignments keep all registers updating from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ptr_d = grant_idx;
          id_d  = ID_W'(grant_idx);
          dsr_d = sel_dsr;
          if (sel_dsr == '0) begin
            dvd_d   = '1;
            rem_d   = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = sel_dvd;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = '0;
    if (state_q == IDLE && grant_vld) bus.i_ready[grant_idx] = 1'b1;
    bus.o_valid = (state_q == DONE);
  end

  assign bus.o_payload_1 = dvd_q;
  assign bus.o_payload_2 = rem_q;
  assign bus.o_id        = id_q;
`ifdef DIV_SCHED_DBZ_FLAG_EN
  assign bus.o_dbz       = (state_q == DONE) && dbz_q;
`endif
endmodule

// File: tb/tb_div_sched_rr.sv
// Bench for div_sched_rr: transaction-level model checked every cycle plus directed literal checks.
module tb_div_sched_rr;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  div_sched_rr_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  div_sched_rr #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    int               id;
    longint           lat;
    logic             dbz;
  } res_t;
  res_t log_q[$];

  // Model state: one outstanding division at most, described at transaction level.
  bit               busy  = 1'b0;
  int               ptr_m = NUM_REQ - 1;
  logic [WIDTH-1:0] mq, mr;
  int               mid;
  logic             mdbz;
  longint           due, hs_cyc, rise_cyc;
  bit               rose;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH-1:0]   dvd, dsr;
    bit                 exp_v;
    bit                 found;
    int                 idx;
    int                 g;
    if (!reset_n) begin
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_i_ready", bus.i_ready, 0);
      check("rst_q", bus.o_payload_1, 0);
      check("rst_r", bus.o_payload_2, 0);
      check("rst_id", bus.o_id, 0);
      busy  = 1'b0;
      ptr_m = NUM_REQ - 1;
    end else begin
      exp_v = busy && (cyc >= due);
      check("o_valid", bus.o_valid, exp_v);
`ifdef DIV_SCHED_DBZ_FLAG_EN
      check("o_dbz", bus.o_dbz, exp_v && mdbz);
`endif
      if (exp_v) begin
        check("o_payload_1", bus.o_payload_1, mq);
        check("o_payload_2", bus.o_payload_2, mr);
        check("o_id", bus.o_id, mid);
        if (!rose) begin
          rose     = 1'b1;
          rise_cyc = cyc;
        end
      end
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      if (!busy) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          idx = (ptr_m + off) % NUM_REQ;
          if (!found && bus.i_valid[idx]) begin
            found        = 1'b1;
            g            = idx;
            exp_rdy[idx] = 1'b1;
          end
        end
      end
      check("i_ready", bus.i_ready, exp_rdy);
      if (exp_v && bus.o_ready) begin
        busy = 1'b0;
        log_q.push_back('{q: mq, r: mr, id: mid, lat: rise_cyc - hs_cyc, dbz: mdbz});
      end else if (found) begin
        dvd    = bus.i_payload_dividend[g*WIDTH +: WIDTH];
        dsr    = bus.i_payload_divisor[g*WIDTH +: WIDTH];
        if (dsr == 0) begin
          mq   = '1;
          mr   = '1;
          mdbz = 1'b1;
          due  = cyc + 1;
        end else begin
          mq   = dvd / dsr;
          mr   = dvd % dsr;
          mdbz = 1'b0;
          due  = cyc + WIDTH + 1;
        end
        mid    = g;
        ptr_m  = g;
        hs_cyc = cyc;
        rose   = 1'b0;
        busy   = 1'b1;
      end
    end
  end

  task automatic set_req(input int k, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dsr);
    bus.i_payload_dividend[k*WIDTH +: WIDTH] = dvd;
    bus.i_payload_divisor[k*WIDTH +: WIDTH]  = dsr;
    bus.i_valid[k] = 1'b1;
  endtask

  task automatic wait_hs_drop(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_ready[k] && n < 200);
    if (!bus.i_ready[k]) check("handshake_timeout", bus.i_ready[k], 1);
    @(posedge clk);
    #1 bus.i_valid[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dsr);
    set_req(k, dvd, dsr);
    wait_hs_drop(k);
  endtask

  task automatic wait_results(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("result_count", log_q.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string name, input int i, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] r, input int id);
    if (i < log_q.size()) begin
      check({name, "_q"}, log_q[i].q, q);
      check({name, "_r"}, log_q[i].r, r);
      check({name, "_id"}, log_q[i].id, id);
    end else begin
      check({name, "_missing"}, log_q.size(), i + 1);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_o_valid", bus.o_valid, 0);
    check("async_i_ready", bus.i_ready, 0);
    check("async_q", bus.o_payload_1, 0);
    check("async_r", bus.o_payload_2, 0);
    check("async_id", bus.o_id, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] tq [4] = '{32'd14, 32'd22, 32'd1, 32'd333};
    logic [WIDTH-1:0] tr [4] = '{32'd2, 32'd2, 32'd0, 32'd1};
    logic [WIDTH-1:0] held_q, held_r;
    int n;

    bus.i_valid            = '0;
    bus.i_payload_dividend = '0;
    bus.i_payload_divisor  = '0;
    bus.o_ready            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", bus.o_valid, 0);
    check("reset_q", bus.o_payload_1, 0);
    reset_n = 1'b1;

    // T1: 17/5 from requester 0
    log_q.delete();
    send(0, 32'd17, 32'd5);
    wait_results(1, 100);
    check_res("t1", 0, 32'd3, 32'd2, 0);
    if (log_q.size() > 0) check("t1_latency", log_q[0].lat, 33);

    // T2: divide by zero from requester 2
    log_q.delete();
    send(2, 32'd100, 32'd0);
    wait_results(1, 100);
    check_res("t2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    if (log_q.size() > 0) check("t2_latency", log_q[0].lat, 1);
`ifdef DIV_SCHED_DBZ_FLAG_EN
    if (log_q.size() > 0) check("t2_dbz", log_q[0].dbz, 1);
`endif

    // T3: all requesters busy after a fresh reset, order 0,1,2,3,0,1,2,3
    reset_pulse();
    log_q.delete();
    set_req(0, 32'd100, 32'd7);
    set_req(1, 32'd200, 32'd9);
    set_req(2, 32'd50, 32'd50);
    set_req(3, 32'd1000, 32'd3);
    wait_results(8, 400);
    bus.i_valid = '0;
    for (int i = 0; i < 8; i++) check_res($sformatf("t3_%0d", i), i, tq[i%4], tr[i%4], i % 4);

    // T4: result held under backpressure, other requester kept waiting
    log_q.delete();
    bus.o_ready = 1'b0;
    send(1, 32'd7, 32'd9);
    set_req(3, 32'd12, 32'd4);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_o_valid_rise", bus.o_valid, 1);
    held_q = bus.o_payload_1;
    held_r = bus.o_payload_2;
    check("t4_q_at_rise", held_q, 0);
    check("t4_r_at_rise", held_r, 7);
    repeat (10) @(negedge clk);
    #1;
    check("t4_hold_valid", bus.o_valid, 1);
    check("t4_hold_q", bus.o_payload_1, 0);
    check("t4_hold_r", bus.o_payload_2, 7);
    check("t4_hold_id", bus.o_id, 1);
    check("t4_no_ready", bus.i_ready, 0);
    @(posedge clk);
    #1 bus.o_ready = 1'b1;
    wait_hs_drop(3);
    wait_results(2, 100);
    check_res("t4a", 0, 32'd0, 32'd7, 1);
    check_res("t4b", 1, 32'd3, 32'd0, 3);

    // T5: extreme operands from requester 3
    log_q.delete();
    send(3, 32'hFFFF_FFFF, 32'd1);
    send(3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_results(2, 200);
    check_res("t5a", 0, 32'hFFFF_FFFF, 32'd0, 3);
    check_res("t5b", 1, 32'd0, 32'h8000_0000, 3);

    // T6: reset mid-RUN discards the division; arbitration restarts at requester 0
    log_q.delete();
    send(0, 32'd17, 32'd5);
    repeat (10) @(posedge clk);
    reset_pulse();
    set_req(0, 32'd45, 32'd6);
    set_req(1, 32'd9, 32'd2);
    wait_hs_drop(0);
    wait_hs_drop(1);
    wait_results(2, 200);
    check_res("t6a", 0, 32'd7, 32'd3, 0);
    check_res("t6b", 1, 32'd4, 32'd1, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
